// File: rtl/ct_had_pkg.sv
// ---------------------------------------------------------------------------
// ct_had_pkg
// Shared definitions for the HAD serial front end: field widths, the start
// bit value, the position of the read/write flag inside HACR and the one-hot
// state encoding of the serial state machine.
// ---------------------------------------------------------------------------
package ct_had_pkg;

    localparam int   HAD_HACR_W  = 16;
    localparam int   HAD_DATA_W  = 64;
    localparam int   HAD_CNT_W   = 7;
    localparam logic START_BIT   = 1'b0;
    localparam int   HACR_RW_BIT = 15;

    // One-hot state encoding, one bit per protocol step
    typedef enum logic [10:0] {
        ST_IDLE = 11'b000_0000_0001,
        ST_HACR = 11'b000_0000_0010,
        ST_HPAR = 11'b000_0000_0100,
        ST_UPDT = 11'b000_0000_1000,
        ST_DEC  = 11'b000_0001_0000,
        ST_LOAD = 11'b000_0010_0000,
        ST_RDAT = 11'b000_0100_0000,
        ST_RPAR = 11'b000_1000_0000,
        ST_WDAT = 11'b001_0000_0000,
        ST_WPAR = 11'b010_0000_0000,
        ST_WEN  = 11'b100_0000_0000
    } sm_state_e;

endpackage

// File: rtl/ct_had_serial_sm.sv
// ---------------------------------------------------------------------------
// ct_had_serial_sm
// Serial front end of the HAD register interface. Deserialises the host bit
// stream (start bit, HACR + odd parity, then write data + odd parity) or
// serialises the selected register read data + odd parity back to the host.
// Bits travel LSB first; all shifting is qualified by jtg_sm_bit_vld.
//
// Ports
//   forever_cpuclk     in   free-running core clock
//   cpurst_b           in   async reset, active low
//   jtg_sm_bit_vld     in   one-cycle pulse marking a serial bit slot
//   jtg_sm_tdi         in   serial input bit, valid with bit_vld
//   jtg_sm_abort       in   level, abandons the current transfer
//   ir_sm_hacr_rw      in   HACR read/write flag from the decoder (1 = read)
//   regs_serial_data   in   selected register read data
//   sm_ir_update_hacr  out  pulse: load serial_xx_data[HACR_W-1:0] into HACR
//   serial_xx_data     out  shift register contents
//   sm_xx_regs_wen     out  pulse: write serial_xx_data to the selected reg
//   sm_jtg_tdo         out  serial output bit
//   sm_jtg_tdo_oe      out  tdo output enable
//   sm_xx_parity_err   out  pulse on a parity mismatch
//   sm_jtg_busy        out  high whenever a transfer is in progress
// ---------------------------------------------------------------------------
module ct_had_serial_sm
    import ct_had_pkg::*;
#(
    parameter int HACR_W = HAD_HACR_W,
    parameter int DATA_W = HAD_DATA_W,
    parameter int CNT_W  = HAD_CNT_W
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              jtg_sm_bit_vld,
    input  logic              jtg_sm_tdi,
    input  logic              jtg_sm_abort,
    input  logic              ir_sm_hacr_rw,
    input  logic [DATA_W-1:0] regs_serial_data,
    output logic              sm_ir_update_hacr,
    output logic [DATA_W-1:0] serial_xx_data,
    output logic              sm_xx_regs_wen,
    output logic              sm_jtg_tdo,
    output logic              sm_jtg_tdo_oe,
    output logic              sm_xx_parity_err,
    output logic              sm_jtg_busy
);

    // Odd parity over the HACR field
    function automatic logic odd_par_hacr(input logic [HACR_W-1:0] field);
        return ~^field;
    endfunction

    // Odd parity over the data field
    function automatic logic odd_par_data(input logic [DATA_W-1:0] field);
        return ~^field;
    endfunction

    sm_state_e         state_r;
    sm_state_e         state_nxt_s;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] shift_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              rpar_r;
    logic              hacr_last_s;
    logic              data_last_s;
    logic              hpar_ok_s;
    logic              wpar_ok_s;
    logic              bit_s;

    // An aborted slot never counts as a bit
    assign bit_s       = jtg_sm_bit_vld & ~jtg_sm_abort;
    assign hacr_last_s = (cnt_r == CNT_W'(HACR_W - 1));
    assign data_last_s = (cnt_r == CNT_W'(DATA_W - 1));
    assign hpar_ok_s   = (jtg_sm_tdi == odd_par_hacr(shift_r[HACR_W-1:0]));
    assign wpar_ok_s   = (jtg_sm_tdi == odd_par_data(shift_r));
    assign serial_xx_data = shift_r;

    // Saturating bit counter increment
    always_comb begin
        cnt_inc_s = cnt_r;
        if (cnt_r == CNT_W'(DATA_W)) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CNT_W'(1);
        end
    end

    // State register
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; abort overrides every state
    always_comb begin
        state_nxt_s = state_r;
        if (jtg_sm_abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (jtg_sm_bit_vld && (jtg_sm_tdi == START_BIT)) begin
                        state_nxt_s = ST_HACR;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_HACR: begin
                    if (bit_s && hacr_last_s) begin
                        state_nxt_s = ST_HPAR;
                    end else begin
                        state_nxt_s = ST_HACR;
                    end
                end
                ST_HPAR: begin
                    if (bit_s) begin
                        state_nxt_s = hpar_ok_s ? ST_UPDT : ST_IDLE;
                    end else begin
                        state_nxt_s = ST_HPAR;
                    end
                end
                ST_UPDT: state_nxt_s = ST_DEC;
                // HACR register is valid in this cycle, so rw can be trusted
                ST_DEC:  state_nxt_s = ir_sm_hacr_rw ? ST_LOAD : ST_WDAT;
                ST_LOAD: state_nxt_s = ST_RDAT;
                ST_RDAT: begin
                    if (bit_s && data_last_s) begin
                        state_nxt_s = ST_RPAR;
                    end else begin
                        state_nxt_s = ST_RDAT;
                    end
                end
                ST_RPAR: begin
                    if (bit_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RPAR;
                    end
                end
                ST_WDAT: begin
                    if (bit_s && data_last_s) begin
                        state_nxt_s = ST_WPAR;
                    end else begin
                        state_nxt_s = ST_WDAT;
                    end
                end
                ST_WPAR: begin
                    if (bit_s) begin
                        state_nxt_s = wpar_ok_s ? ST_WEN : ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WPAR;
                    end
                end
                ST_WEN:  state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Shifter and counter next values; abort freezes both
    always_comb begin
        shift_nxt_s = shift_r;
        cnt_nxt_s   = cnt_r;
        if (jtg_sm_abort) begin
            shift_nxt_s = shift_r;
            cnt_nxt_s   = cnt_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (jtg_sm_bit_vld && (jtg_sm_tdi == START_BIT)) begin
                        shift_nxt_s = '0;
                        cnt_nxt_s   = '0;
                    end else begin
                        shift_nxt_s = shift_r;
                    end
                end
                ST_HACR: begin
                    if (bit_s) begin
                        shift_nxt_s[HACR_W-1:0] = {jtg_sm_tdi, shift_r[HACR_W-1:1]};
                        cnt_nxt_s               = cnt_inc_s;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                ST_DEC: cnt_nxt_s = '0;
                ST_LOAD: begin
                    shift_nxt_s = regs_serial_data;
                    cnt_nxt_s   = '0;
                end
                ST_RDAT: begin
                    if (bit_s) begin
                        shift_nxt_s = {1'b0, shift_r[DATA_W-1:1]};
                        cnt_nxt_s   = cnt_inc_s;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                ST_WDAT: begin
                    if (bit_s) begin
                        shift_nxt_s = {jtg_sm_tdi, shift_r[DATA_W-1:1]};
                        cnt_nxt_s   = cnt_inc_s;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                default: begin
                    shift_nxt_s = shift_r;
                    cnt_nxt_s   = cnt_r;
                end
            endcase
        end
    end

    // Shifter, counter and read-parity registers
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            shift_r <= '0;
            cnt_r   <= '0;
            rpar_r  <= 1'b0;
        end else begin
            shift_r <= shift_nxt_s;
            cnt_r   <= cnt_nxt_s;
            // Parity of the whole read word must be taken before it shifts out
            if ((state_r == ST_LOAD) && !jtg_sm_abort) begin
                rpar_r <= odd_par_data(regs_serial_data);
            end else begin
                rpar_r <= rpar_r;
            end
        end
    end

    // Output decode; abort masks every pulse in its own cycle
    always_comb begin
        sm_ir_update_hacr = (state_r == ST_UPDT) & ~jtg_sm_abort;
        sm_xx_regs_wen    = (state_r == ST_WEN) & ~jtg_sm_abort;
        sm_xx_parity_err  = bit_s & (((state_r == ST_HPAR) & ~hpar_ok_s) |
                                     ((state_r == ST_WPAR) & ~wpar_ok_s));
        sm_jtg_busy       = (state_r != ST_IDLE);
        sm_jtg_tdo_oe     = (state_r == ST_RDAT) | (state_r == ST_RPAR);
        case (state_r)
            ST_RDAT: sm_jtg_tdo = shift_r[0];
            ST_RPAR: sm_jtg_tdo = rpar_r;
            default: sm_jtg_tdo = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_ct_had_serial_sm.sv
// ---------------------------------------------------------------------------
// tb_ct_had_serial_sm
// Directed bench for ct_had_serial_sm. Inputs change 1 time unit after the
// rising clock edge; a negedge monitor records pulses and tdo bits per slot.
// ---------------------------------------------------------------------------
module tb_ct_had_serial_sm;
    import ct_had_pkg::*;

    logic        forever_cpuclk = 1'b0;
    logic        cpurst_b;
    logic        jtg_sm_bit_vld;
    logic        jtg_sm_tdi;
    logic        jtg_sm_abort;
    logic        ir_sm_hacr_rw;
    logic [63:0] regs_serial_data;
    logic        sm_ir_update_hacr;
    logic [63:0] serial_xx_data;
    logic        sm_xx_regs_wen;
    logic        sm_jtg_tdo;
    logic        sm_jtg_tdo_oe;
    logic        sm_xx_parity_err;
    logic        sm_jtg_busy;

    int vec_cnt    = 0;
    int miscmp_cnt = 0;
    int gap_s      = 0;

    int          upd_n = 0;
    int          wen_n = 0;
    int          err_n = 0;
    int          rd_n  = 0;
    logic        rd_bits [0:1023];

    logic [15:0] wr_hacr;
    logic [15:0] rd_hacr;
    logic [63:0] wr_data;

    ct_had_serial_sm dut (
        .forever_cpuclk    (forever_cpuclk),
        .cpurst_b          (cpurst_b),
        .jtg_sm_bit_vld    (jtg_sm_bit_vld),
        .jtg_sm_tdi        (jtg_sm_tdi),
        .jtg_sm_abort      (jtg_sm_abort),
        .ir_sm_hacr_rw     (ir_sm_hacr_rw),
        .regs_serial_data  (regs_serial_data),
        .sm_ir_update_hacr (sm_ir_update_hacr),
        .serial_xx_data    (serial_xx_data),
        .sm_xx_regs_wen    (sm_xx_regs_wen),
        .sm_jtg_tdo        (sm_jtg_tdo),
        .sm_jtg_tdo_oe     (sm_jtg_tdo_oe),
        .sm_xx_parity_err  (sm_xx_parity_err),
        .sm_jtg_busy       (sm_jtg_busy)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    // Mid-cycle monitor: pulse counters and tdo value of every enabled bit slot
    always @(negedge forever_cpuclk) begin
        if (sm_ir_update_hacr) upd_n <= upd_n + 1;
        if (sm_xx_regs_wen)    wen_n <= wen_n + 1;
        if (sm_xx_parity_err)  err_n <= err_n + 1;
        if (sm_jtg_tdo_oe && jtg_sm_bit_vld && (rd_n < 1024)) begin
            rd_bits[rd_n] <= sm_jtg_tdo;
            rd_n          <= rd_n + 1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge forever_cpuclk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        idle(gap_s);
        jtg_sm_bit_vld = 1'b1;
        jtg_sm_tdi     = b;
        idle(1);
        jtg_sm_bit_vld = 1'b0;
        jtg_sm_tdi     = 1'b1;
    endtask

    task automatic send_field(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[i]);
    endtask

    task automatic send_hacr(input logic [15:0] h, input logic par);
        send_bit(START_BIT);
        send_field({48'd0, h}, 16);
        send_bit(par);
    endtask

    task automatic do_write(input logic [15:0] h, input logic [63:0] d);
        int u0 = upd_n;
        int w0 = wen_n;
        int e0 = err_n;
        ir_sm_hacr_rw = 1'b0;
        send_hacr(h, ~^h);
        check_val("wr_upd_pulse", 64'(sm_ir_update_hacr), 64'd1);
        check_val("wr_upd_hacr", 64'(serial_xx_data[15:0]), 64'(h));
        idle(4);
        send_field(d, 64);
        send_bit(~^d);
        check_val("wr_wen_pulse", 64'(sm_xx_regs_wen), 64'd1);
        check_val("wr_wen_data", serial_xx_data, d);
        idle(1);
        check_val("wr_busy_end", 64'(sm_jtg_busy), 64'd0);
        check_val("wr_upd_count", 64'(upd_n - u0), 64'd1);
        check_val("wr_wen_count", 64'(wen_n - w0), 64'd1);
        check_val("wr_err_count", 64'(err_n - e0), 64'd0);
    endtask

    task automatic do_read(input logic [15:0] h, input logic [63:0] d, input logic exp_par);
        int          base = rd_n;
        logic [63:0] got  = '0;
        ir_sm_hacr_rw    = 1'b1;
        regs_serial_data = d;
        send_hacr(h, ~^h);
        check_val("rd_upd_pulse", 64'(sm_ir_update_hacr), 64'd1);
        idle(2);
        check_val("rd_oe_load", 64'(sm_jtg_tdo_oe), 64'd0);
        idle(1);
        check_val("rd_oe_first", 64'(sm_jtg_tdo_oe), 64'd1);
        check_val("rd_tdo_first", 64'(sm_jtg_tdo), 64'(d[0]));
        idle(1);
        for (int i = 0; i < 65; i++) send_bit(1'b1);
        check_val("rd_oe_end", 64'(sm_jtg_tdo_oe), 64'd0);
        check_val("rd_busy_end", 64'(sm_jtg_busy), 64'd0);
        check_val("rd_slot_count", 64'(rd_n - base), 64'd65);
        for (int i = 0; i < 64; i++) got[i] = rd_bits[base + i];
        check_val("rd_data", got, d);
        check_val("rd_parity", 64'(rd_bits[base + 64]), 64'(exp_par));
        ir_sm_hacr_rw = 1'b0;
    endtask

    initial begin
        int u0;
        int w0;
        int e0;
        cpurst_b         = 1'b0;
        jtg_sm_bit_vld   = 1'b0;
        jtg_sm_tdi       = 1'b1;
        jtg_sm_abort     = 1'b0;
        ir_sm_hacr_rw    = 1'b0;
        regs_serial_data = '0;
        wr_hacr          = 16'h0200;
        rd_hacr          = 16'h0200 | (16'h0001 << HACR_RW_BIT);
        wr_data          = 64'h0123_4567_89AB_CDEF;

        // Reset state
        idle(3);
        check_val("rst_data", serial_xx_data, 64'd0);
        check_val("rst_tdo", 64'(sm_jtg_tdo), 64'd1);
        check_val("rst_oe", 64'(sm_jtg_tdo_oe), 64'd0);
        check_val("rst_busy", 64'(sm_jtg_busy), 64'd0);
        check_val("rst_pulses", {61'd0, sm_ir_update_hacr, sm_xx_regs_wen, sm_xx_parity_err}, 64'd0);
        cpurst_b = 1'b1;
        idle(2);

        // Idle-line ones are not start bits
        send_bit(1'b1);
        send_bit(1'b1);
        check_val("idle_ones", 64'(sm_jtg_busy), 64'd0);

        // Back-to-back bit slots, then every 5th cycle
        for (int g = 0; g <= 4; g += 4) begin
            gap_s = g;
            do_write(wr_hacr, wr_data);
            do_read(rd_hacr, 64'd1, 1'b0);
            do_read(rd_hacr, wr_data, 1'b1);
        end
        gap_s = 0;

        // Bad HACR parity
        u0 = upd_n;
        e0 = err_n;
        send_hacr(wr_hacr, 1'b1);
        check_val("hpar_no_upd", 64'(sm_ir_update_hacr), 64'd0);
        check_val("hpar_busy", 64'(sm_jtg_busy), 64'd0);
        check_val("hpar_err_count", 64'(err_n - e0), 64'd1);
        check_val("hpar_upd_count", 64'(upd_n - u0), 64'd0);

        // Bad write-data parity
        w0 = wen_n;
        e0 = err_n;
        send_hacr(wr_hacr, 1'b0);
        idle(4);
        send_field(wr_data, 64);
        send_bit(1'b0);
        idle(1);
        check_val("wpar_busy", 64'(sm_jtg_busy), 64'd0);
        check_val("wpar_err_count", 64'(err_n - e0), 64'd1);
        check_val("wpar_wen_count", 64'(wen_n - w0), 64'd0);

        // Abort after 30 write-data bits, together with a bit slot
        w0 = wen_n;
        e0 = err_n;
        send_hacr(wr_hacr, 1'b0);
        idle(4);
        send_field(wr_data, 30);
        jtg_sm_abort   = 1'b1;
        jtg_sm_bit_vld = 1'b1;
        jtg_sm_tdi     = 1'b0;
        idle(1);
        jtg_sm_abort   = 1'b0;
        jtg_sm_bit_vld = 1'b0;
        jtg_sm_tdi     = 1'b1;
        check_val("abort_busy", 64'(sm_jtg_busy), 64'd0);
        check_val("abort_hold", serial_xx_data, {wr_data[29:0], 34'd0});
        idle(6);
        check_val("abort_wen_count", 64'(wen_n - w0), 64'd0);
        check_val("abort_err_count", 64'(err_n - e0), 64'd0);
        do_write(wr_hacr, 64'hFEDC_BA98_7654_3210);

        // Reset in the middle of a read
        ir_sm_hacr_rw    = 1'b1;
        regs_serial_data = wr_data;
        send_hacr(rd_hacr, ~^rd_hacr);
        idle(4);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        check_val("midrd_oe_before", 64'(sm_jtg_tdo_oe), 64'd1);
        cpurst_b = 1'b0;
        #1;
        check_val("midrd_tdo", 64'(sm_jtg_tdo), 64'd1);
        check_val("midrd_oe", 64'(sm_jtg_tdo_oe), 64'd0);
        check_val("midrd_busy", 64'(sm_jtg_busy), 64'd0);
        idle(2);
        cpurst_b      = 1'b1;
        ir_sm_hacr_rw = 1'b0;
        idle(2);
        do_write(wr_hacr, wr_data);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
